// File: rtl/spart_tx_ctrl_pkg.sv
// Shared definitions for the SPART transmit controller: MMIO addresses,
// FSM state encoding and status-word bit positions.
package spart_tx_ctrl_pkg;

    localparam logic [31:0] TX_ADDR     = 32'h1000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h1000_0004;

    localparam int ST_READY     = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_IDLE      = 2;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_LOW  = 2'd2,
        S_WAIT_HIGH = 2'd3
    } tx_state_e;

endpackage

// File: rtl/spart_tx_ctrl_fifo.sv
// Flop-based byte FIFO (DEPTH x 8) with push, pop and flush; head is shown
// combinationally so the controller can latch it on the pop cycle.
module tx_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [7:0]                 wr_data,
    output logic [7:0]                 rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rd_data = mem_q[head_q];
    assign count   = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push_ok) tail_d = tail_q + 1'b1;
            if (pop_ok)  head_d = head_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[tail_q] <= wr_data;
    end

endmodule

// File: rtl/spart_tx_ctrl.sv
// MMIO transmit controller: decodes CPU stores, queues bytes, and feeds
// spart_tx one byte at a time over the trmt/tbr handshake.
module spart_tx_ctrl #(
    parameter int          DEPTH       = 8,
    parameter logic [31:0] TX_ADDR     = spart_tx_ctrl_pkg::TX_ADDR,
    parameter logic [31:0] STATUS_ADDR = spart_tx_ctrl_pkg::STATUS_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_wr,
    input  logic        mem_en,
    output logic        dmem_wr_en,
    output logic        status_sel,
    output logic [31:0] status_rd_data,
    output logic        cpu_stall,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tbr
);
    import spart_tx_ctrl_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    tx_state_e      state_q, state_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           wait_cnt_q, wait_cnt_d;
    logic           tx_hit, st_hit, tx_wr, ctl_wr, flush, push, pop;
    logic [7:0]     fifo_head;
    logic [CW-1:0]  fifo_count;
    logic           fifo_full, fifo_empty, idle;

    assign tx_hit     = (mem_addr == TX_ADDR);
    assign st_hit     = (mem_addr == STATUS_ADDR);
    assign tx_wr      = mem_wr & mem_en & tx_hit;
    assign ctl_wr     = mem_wr & mem_en & st_hit;
    assign flush      = ctl_wr & mem_wr_data[0];
    assign dmem_wr_en = mem_wr & mem_en & ~(tx_hit | st_hit);
    assign status_sel = st_hit;

    // A full FIFO still accepts a store when the FSM frees a slot this cycle.
    assign push      = tx_wr & (~fifo_full | pop);
    assign cpu_stall = tx_wr & fifo_full & ~pop;

    tx_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (mem_wr_data[7:0]),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        wait_cnt_d = wait_cnt_q;
        pop        = 1'b0;
        trmt       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && tbr) begin
                    pop       = 1'b1;
                    tx_data_d = fifo_head;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                trmt       = 1'b1;
                wait_cnt_d = 1'b0;
                state_d    = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                // tbr held high for two cycles means spart_tx took the byte already.
                if (!tbr || wait_cnt_q) state_d = S_WAIT_HIGH;
                else                    wait_cnt_d = 1'b1;
            end
            S_WAIT_HIGH: begin
                if (tbr) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tx_data_q  <= 8'h00;
            wait_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign tx_data = tx_data_q;
    assign idle    = (state_q == S_IDLE) & fifo_empty & tbr;

    always_comb begin
        status_rd_data                          = 32'd0;
        status_rd_data[ST_COUNT_LSB +: 8]       = 8'(fifo_count);
        status_rd_data[ST_IDLE]                 = idle;
        status_rd_data[ST_EMPTY]                = fifo_empty;
        status_rd_data[ST_READY]                = ~fifo_full;
    end

endmodule

// File: tb/tb_spart_tx_ctrl.sv
// Scoreboard bench for spart_tx_ctrl with a behavioural spart_tx busy model.
module tb_spart_tx_ctrl;
    import spart_tx_ctrl_pkg::*;

    localparam int DEPTH = 8;
    localparam int BUSY  = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr, mem_wr_data;
    logic        mem_wr, mem_en;
    logic        dmem_wr_en, status_sel, cpu_stall, trmt, tbr;
    logic [31:0] status_rd_data;
    logic [7:0]  tx_data;

    logic        model_tbr = 1'b1;
    logic        hold_low  = 1'b0;
    int          busy      = 0;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    int          trmt_cnt  = 0;
    int          stall_cnt = 0;
    logic [7:0]  first_stall_data = 8'h00;
    logic        prev_trmt = 1'b0;

    assign tbr = model_tbr & ~hold_low;

    always #5 clk = ~clk;

    spart_tx_ctrl #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_wr_data    (mem_wr_data),
        .mem_wr         (mem_wr),
        .mem_en         (mem_en),
        .dmem_wr_en     (dmem_wr_en),
        .status_sel     (status_sel),
        .status_rd_data (status_rd_data),
        .cpu_stall      (cpu_stall),
        .trmt           (trmt),
        .tx_data        (tx_data),
        .tbr            (tbr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_word(input int cnt, input logic idl);
        logic [31:0] w;
        w        = 32'd0;
        w[15:8]  = 8'(cnt);
        w[2]     = idl;
        w[1]     = (cnt == 0);
        w[0]     = (cnt < DEPTH);
        return w;
    endfunction

    // spart_tx stand-in: tbr drops on the load strobe and returns BUSY cycles later.
    always @(posedge clk) begin
        if (trmt) begin
            model_tbr <= 1'b0;
            busy      <= BUSY;
        end else if (busy > 0) begin
            busy <= busy - 1;
            if (busy == 1) model_tbr <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (trmt) begin
            trmt_cnt++;
            chk("trmt_one_cycle", {31'd0, prev_trmt}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_trmt", 32'd1, 32'd0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                $display("tx byte %02h (expected %02h)", tx_data, e);
                chk("tx_data", {24'd0, tx_data}, {24'd0, e});
            end
        end
        prev_trmt = trmt;
    end

    task automatic cpu_store(input logic [31:0] addr, input logic [31:0] data, input bit track);
        bit stalled;
        bit accepted;
        accepted = 1'b0;
        @(negedge clk);
        mem_addr = addr; mem_wr_data = data; mem_wr = 1'b1; mem_en = 1'b1;
        for (int t = 0; t < 400; t++) begin
            #1;
            stalled = cpu_stall;
            if (stalled) begin
                if (stall_cnt == 0) first_stall_data = data[7:0];
                stall_cnt++;
            end
            @(posedge clk);
            if (!stalled) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) chk("store_timeout", 32'd0, 32'd1);
        if (accepted && track) exp_q.push_back(data[7:0]);
        #1;
        mem_wr = 1'b0; mem_en = 1'b0;
    endtask

    task automatic probe_dmem(input logic [31:0] addr, input logic exp, input string tag);
        @(negedge clk);
        mem_addr = addr; mem_wr_data = 32'd0; mem_wr = 1'b1; mem_en = 1'b1;
        #1;
        chk(tag, {31'd0, dmem_wr_en}, {31'd0, exp});
        #1;
        mem_wr = 1'b0; mem_en = 1'b0;
    endtask

    task automatic read_status(input logic [31:0] exp, input string tag);
        @(negedge clk);
        mem_addr = STATUS_ADDR; mem_wr = 1'b0; mem_en = 1'b1;
        #1;
        chk({tag, "_sel"}, {31'd0, status_sel}, 32'd1);
        chk(tag, status_rd_data, exp);
        mem_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && status_rd_data[ST_IDLE]) done = 1'b1;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int tcnt;
        rst = 1'b1; mem_addr = 32'd0; mem_wr_data = 32'd0; mem_wr = 1'b0; mem_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_trmt", {31'd0, trmt}, 32'd0);
        chk("reset_tx_data", {24'd0, tx_data}, 32'd0);
        rst = 1'b0;

        // Reset state and address decode
        read_status(32'h0000_0007, "reset_status");
        probe_dmem(TX_ADDR, 1'b0, "dmem_tx_addr");
        probe_dmem(STATUS_ADDR, 1'b0, "dmem_status_addr");
        probe_dmem(32'h0000_0100, 1'b1, "dmem_plain_addr");
        read_status(status_word(0, 1'b1), "fifo_untouched");

        // Single byte: trmt two cycles after the accepting edge
        cpu_store(TX_ADDR, 32'h41, 1'b1);
        @(negedge clk);
        chk("trmt_early", {31'd0, trmt}, 32'd0);
        @(negedge clk);
        chk("trmt_latency", {31'd0, trmt}, 32'd1);
        chk("byte_A", {24'd0, tx_data}, 32'h41);
        wait_idle(100, "idle_after_A");

        // Nine stores with transmitter held busy: stall on the 9th, then push+pop at full
        @(negedge clk);
        hold_low = 1'b1;
        fork
            begin
                for (int i = 0; i < 9; i++) cpu_store(TX_ADDR, 32'h30 + 32'(i), 1'b1);
            end
            begin
                for (int k = 0; k < 200 && stall_cnt == 0; k++) @(negedge clk);
                chk("stall_seen", {31'd0, stall_cnt != 0}, 32'd1);
                chk("stall_byte", {24'd0, first_stall_data}, 32'h38);
                chk("full_status", status_rd_data, status_word(8, 1'b0));
                hold_low = 1'b0;
                @(posedge clk);
                #2;
                chk("count_push_pop_full", {24'd0, status_rd_data[15:8]}, 32'd8);
            end
        join
        chk("stall_cycles", stall_cnt, 32'd1);
        wait_idle(600, "drain_nine");

        // Flush with one byte in flight and three queued
        for (int i = 0; i < 4; i++) cpu_store(TX_ADDR, 32'h50 + 32'(i), 1'b1);
        read_status(status_word(3, 1'b0), "pre_flush");
        cpu_store(STATUS_ADDR, 32'h2, 1'b0);
        read_status(status_word(3, 1'b0), "ctl_bit0_clear_ignored");
        cpu_store(STATUS_ADDR, 32'h1, 1'b0);
        chk("flush_count", {24'd0, status_rd_data[15:8]}, 32'd0);
        exp_q.delete();
        tcnt = trmt_cnt;
        wait_idle(100, "idle_after_flush");
        repeat (5) @(negedge clk);
        chk("no_trmt_after_flush", trmt_cnt, tcnt);

        // Asynchronous reset while waiting for tbr to rise, four bytes queued
        for (int i = 0; i < 5; i++) cpu_store(TX_ADDR, 32'h60 + 32'(i), 1'b1);
        chk("queued_before_rst", {24'd0, status_rd_data[15:8]}, 32'd4);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_trmt", {31'd0, trmt}, 32'd0);
        chk("rst_status", status_rd_data[15:0], {16'd0, status_word(0, tbr)} & 32'h0000_FFFF);
        exp_q.delete();
        tcnt = trmt_cnt;
        @(negedge clk);
        rst = 1'b0;
        wait_idle(100, "idle_after_rst");
        repeat (5) @(negedge clk);
        chk("no_trmt_after_rst", trmt_cnt, tcnt);
        cpu_store(TX_ADDR, 32'h5A, 1'b1);
        wait_idle(100, "drain_after_rst");
        chk("final_trmt_count", trmt_cnt, tcnt + 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
